// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, step count, DIV/DIVU op codes
// and the operand-magnitude helper used when the divider latches its operands.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_STEPS = 32;

    localparam logic [3:0] ALUC_DIV  = 4'b1110;
    localparam logic [3:0] ALUC_DIVU = 4'b1111;

    // 0x80000000 negates to itself, which read unsigned is the correct magnitude.
    function automatic logic [31:0] div_mag(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div32_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor magnitude, keep the difference unless it borrowed.
module div32_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] trial;
    logic             borrow_low;
    logic             borrow;

    assign shifted = {rem[WIDTH-2:0], in_bit};
    assign {borrow_low, trial} = {1'b0, shifted} - {1'b0, dmag};

    // A set rem MSB means the true shifted value is >= 2^WIDTH and can never
    // borrow; the low WIDTH bits of the difference are still exact in that case.
    assign borrow  = borrow_low & ~rem[WIDTH-1];
    assign rem_out = borrow ? shifted : trial;
    assign q_bit   = ~borrow;

endmodule

// File: rtl/div32_seq.sv
// Iterative 32-bit restoring divider (DIV/DIVU), one quotient bit per cycle.
// Optional macro DIV32_ZERO_TRAP_EN: zero divisor finishes immediately with div_zero set.
import alu_pkg::*;

module div32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_reg;
    logic [WIDTH-1:0] dq_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dmag_reg;
    logic [CNT_W-1:0] count_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             ovf_pend_reg;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_final;
    logic             start_ovf;

    // dq holds the unconsumed dividend bits at the top and the quotient bits below.
    assign q_final   = {dq_reg[WIDTH-2:0], q_bit};
    assign start_ovf = sign & (dividend == MIN_NEG) & (&divisor);

    div32_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_reg),
        .in_bit  (dq_reg[WIDTH-1]),
        .dmag    (dmag_reg),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

`ifdef DIV32_ZERO_TRAP_EN
    logic div_zero_reg;
    assign div_zero = div_zero_reg;
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            dq_reg       <= '0;
            rem_reg      <= '0;
            dmag_reg     <= '0;
            count_reg    <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            ovf_pend_reg <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            overflow     <= 1'b0;
`ifdef DIV32_ZERO_TRAP_EN
            div_zero_reg <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        dq_reg       <= div_mag(dividend, sign);
                        dmag_reg     <= div_mag(divisor, sign);
                        neg_q_reg    <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_reg    <= sign & dividend[WIDTH-1];
                        ovf_pend_reg <= start_ovf;
                        rem_reg      <= '0;
                        count_reg    <= '0;
                        overflow     <= 1'b0;
`ifdef DIV32_ZERO_TRAP_EN
                        if (divisor == '0) begin
                            quotient     <= '1;
                            remainder    <= dividend;
                            div_zero_reg <= 1'b1;
                            done         <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            div_zero_reg <= 1'b0;
                            busy         <= 1'b1;
                            state_reg    <= RUN;
                        end
`else
                        busy      <= 1'b1;
                        state_reg <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem_reg   <= rem_next;
                    dq_reg    <= q_final;
                    count_reg <= count_reg + CNT_W'(1);
                    // Results are loaded on the final step so they are valid with done.
                    if (count_reg == LAST_STEP) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= neg_q_reg ? (~q_final + WIDTH'(1)) : q_final;
                        remainder <= neg_r_reg ? (~rem_next + WIDTH'(1)) : rem_next;
                        overflow  <= ovf_pend_reg;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
